mem_region_mapper: RTL

- Parametrised successor to the fixed four-window memory mapper.
- Decodes fetch and execute-stage addresses against NUM_REGIONS runtime-programmable regions, each with start, end, R/W/X attributes and a lock bit.
- Issues one-hot region selects and base-relative translated addresses, and flags fetch/load/store access faults.
- Latches the first fault into sticky capture registers for the trap unit.
- Sits between the pipeline (IF/EX) and the ROM/RAM/IO memories.

---
 rtl/mem_region_mapper_pkg.sv | 51 +++++
 rtl/mem_region_match.sv | 19 +
 rtl/mem_region_mapper.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_region_mapper_pkg.sv
// Shared types and constants for mem_region_mapper.
// Holds attribute bit positions, config field codes, fault cause codes and
// the reset region address map.
package mem_region_mapper_pkg;

  // XLEN encodings: data width W = 1 << (XLEN + 4)
  localparam int unsigned XLEN_32B = 1;
  localparam int unsigned XLEN_64B = 2;

  // Attribute bit positions, format {L,X,W,R}
  localparam int unsigned ATTR_R = 0;
  localparam int unsigned ATTR_W = 1;
  localparam int unsigned ATTR_X = 2;
  localparam int unsigned ATTR_L = 3;
  localparam int unsigned ATTR_WIDTH = 4;

  // Config field codes
  localparam logic [1:0] CFG_START = 2'd0;
  localparam logic [1:0] CFG_END   = 2'd1;
  localparam logic [1:0] CFG_ATTR  = 2'd2;
  localparam logic [1:0] CFG_RSVD  = 2'd3;

  // Fault cause codes
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_FETCH = 2'd1;
  localparam logic [1:0] CAUSE_LOAD  = 2'd2;
  localparam logic [1:0] CAUSE_STORE = 2'd3;

  // Reset region address map (inclusive bounds)
  localparam logic [63:0] TRAP_LO     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] TEXT_HI     = 64'h0000_0000_0000_3FFF;
  localparam logic [63:0] ROM_DATA_LO = 64'h0000_0000_0000_4000;
  localparam logic [63:0] ROM_DATA_HI = 64'h0000_0000_0000_7FFF;
  localparam logic [63:0] GLOBAL_LO   = 64'h0000_0000_1000_0000;
  localparam logic [63:0] M_STACK_HI  = 64'h0000_0000_1000_FFFF;
  localparam logic [63:0] IO_LO       = 64'h0000_0000_2000_0000;
  localparam logic [63:0] IO_HI       = 64'h0000_0000_2000_00FF;

  typedef struct packed {
    logic l;
    logic x;
    logic w;
    logic r;
  } attr_t;

  // A slot takes part in decode only when at least one access right is set
  function automatic logic attr_enabled(attr_t a);
    return a.x | a.w | a.r;
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// Single-slot comparator: hit when the slot is enabled and start <= addr <= end.
module mem_region_match
  import mem_region_mapper_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_start,
  input  logic [W-1:0] i_end,
  input  attr_t        i_attr,
  output logic         o_hit
);

  // Unsigned inclusive window check; start > end never hits
  always_comb begin
    o_hit = attr_enabled(i_attr) && (i_addr >= i_start) && (i_addr <= i_end);
  end

endmodule

// File: rtl/mem_region_mapper.sv
// Programmable region decoder with R/W/X/L attributes, address translation
// and sticky first-fault capture.
// Optional: define MEM_REGION_MAPPER_FAULT_CNT_EN to add o_fault_cnt, a
// saturating count of cycles with any fault asserted.
module mem_region_mapper
  import mem_region_mapper_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_64B,
  parameter int unsigned NUM_REGIONS = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_REGIONS),
  localparam int unsigned W          = 1 << (XLEN + 4),
  parameter logic [W-1:0] RST_START_0 = W'(TRAP_LO),
  parameter logic [W-1:0] RST_START_1 = W'(ROM_DATA_LO),
  parameter logic [W-1:0] RST_START_2 = W'(GLOBAL_LO),
  parameter logic [W-1:0] RST_START_3 = W'(IO_LO),
  parameter logic [W-1:0] RST_END_0   = W'(TEXT_HI),
  parameter logic [W-1:0] RST_END_1   = W'(ROM_DATA_HI),
  parameter logic [W-1:0] RST_END_2   = W'(M_STACK_HI),
  parameter logic [W-1:0] RST_END_3   = W'(IO_HI),
  parameter attr_t RST_ATTR_0 = 4'b1100,
  parameter attr_t RST_ATTR_1 = 4'b1001,
  parameter attr_t RST_ATTR_2 = 4'b1011,
  parameter attr_t RST_ATTR_3 = 4'b1011
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [W-1:0]           i_fetch_addr,
  input  logic [W-1:0]           i_alu_out_e,
  input  logic                   i_lw_e,
  input  logic                   i_sw_e,
  input  logic                   i_cfg_we,
  input  logic [IDX_W-1:0]       i_cfg_idx,
  input  logic [1:0]             i_cfg_field,
  input  logic [W-1:0]           i_cfg_wdata,
  input  logic                   i_fault_clr,
  output logic [NUM_REGIONS-1:0] o_fetch_sel,
  output logic [NUM_REGIONS-1:0] o_ex_sel,
  output logic [W-1:0]           o_fetch_translated_addr,
  output logic [W-1:0]           o_ex_translated_addr,
  output logic                   o_bad_addr_f,
  output logic                   o_bad_addr_load_e,
  output logic                   o_bad_addr_store_e,
  output logic                   o_fault_valid,
  output logic [W-1:0]           o_fault_addr,
`ifdef MEM_REGION_MAPPER_FAULT_CNT_EN
  output logic [15:0]            o_fault_cnt,
`endif
  output logic [1:0]             o_fault_cause
);

  logic [W-1:0] start_q [NUM_REGIONS];
  logic [W-1:0] end_q   [NUM_REGIONS];
  attr_t        attr_q  [NUM_REGIONS];

  logic [NUM_REGIONS-1:0] f_hit;
  logic [NUM_REGIONS-1:0] e_hit;
  logic                   f_hit_any;
  logic                   e_hit_any;
  logic [IDX_W-1:0]       f_idx;
  logic [IDX_W-1:0]       e_idx;
  logic                   any_fault;

  logic                   fault_valid_q, fault_valid_d;
  logic [W-1:0]           fault_addr_q, fault_addr_d;
  logic [1:0]             fault_cause_q, fault_cause_d;

  // Per-slot comparators for the fetch and execute ports
  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_match
    mem_region_match #(.W(W)) u_fetch_match (
      .i_addr (i_fetch_addr),
      .i_start(start_q[k]),
      .i_end  (end_q[k]),
      .i_attr (attr_q[k]),
      .o_hit  (f_hit[k])
    );
    mem_region_match #(.W(W)) u_ex_match (
      .i_addr (i_alu_out_e),
      .i_start(start_q[k]),
      .i_end  (end_q[k]),
      .i_attr (attr_q[k]),
      .o_hit  (e_hit[k])
    );
  end

  // Priority encoders: scanning downward leaves the lowest hitting index
  always_comb begin
    f_hit_any = 1'b0;
    e_hit_any = 1'b0;
    f_idx     = '0;
    e_idx     = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (f_hit[k]) begin
        f_hit_any = 1'b1;
        f_idx     = IDX_W'(k);
      end
      if (e_hit[k]) begin
        e_hit_any = 1'b1;
        e_idx     = IDX_W'(k);
      end
    end
  end

  // Selects, translation and access faults
  always_comb begin
    o_fetch_sel = f_hit_any ? (NUM_REGIONS'(1) << f_idx) : '0;
    o_ex_sel    = (e_hit_any && (i_lw_e || i_sw_e)) ? (NUM_REGIONS'(1) << e_idx) : '0;
    o_fetch_translated_addr = f_hit_any ? (i_fetch_addr - start_q[f_idx]) : i_fetch_addr;
    o_ex_translated_addr    = e_hit_any ? (i_alu_out_e - start_q[e_idx]) : i_alu_out_e;
    o_bad_addr_f       = !f_hit_any || !attr_q[f_idx].x;
    o_bad_addr_load_e  = i_lw_e && (!e_hit_any || !attr_q[e_idx].r);
    o_bad_addr_store_e = i_sw_e && (!e_hit_any || !attr_q[e_idx].w);
    any_fault = o_bad_addr_f || o_bad_addr_load_e || o_bad_addr_store_e;
  end

  // Region table: reset map, then config writes to unlocked slots
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        if (k == 0) begin
          start_q[k] <= RST_START_0; end_q[k] <= RST_END_0; attr_q[k] <= RST_ATTR_0;
        end else if (k == 1) begin
          start_q[k] <= RST_START_1; end_q[k] <= RST_END_1; attr_q[k] <= RST_ATTR_1;
        end else if (k == 2) begin
          start_q[k] <= RST_START_2; end_q[k] <= RST_END_2; attr_q[k] <= RST_ATTR_2;
        end else if (k == 3) begin
          start_q[k] <= RST_START_3; end_q[k] <= RST_END_3; attr_q[k] <= RST_ATTR_3;
        end else begin
          start_q[k] <= '0; end_q[k] <= '0; attr_q[k] <= '0;
        end
      end
    end else if (i_cfg_we) begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        if ((IDX_W'(k) == i_cfg_idx) && !attr_q[k].l) begin
          case (i_cfg_field)
            CFG_START: start_q[k] <= i_cfg_wdata;
            CFG_END:   end_q[k]   <= i_cfg_wdata;
            CFG_ATTR:  attr_q[k]  <= attr_t'(i_cfg_wdata[ATTR_WIDTH-1:0]);
            default:   ;
          endcase
        end
      end
    end
  end

  // First-fault capture: clear first, then capture store > load > fetch
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;
    if (i_fault_clr) begin
      fault_valid_d = 1'b0;
      fault_addr_d  = '0;
      fault_cause_d = CAUSE_NONE;
    end
    if (!fault_valid_d && any_fault) begin
      fault_valid_d = 1'b1;
      if (o_bad_addr_store_e) begin
        fault_addr_d  = i_alu_out_e;
        fault_cause_d = CAUSE_STORE;
      end else if (o_bad_addr_load_e) begin
        fault_addr_d  = i_alu_out_e;
        fault_cause_d = CAUSE_LOAD;
      end else begin
        fault_addr_d  = i_fetch_addr;
        fault_cause_d = CAUSE_FETCH;
      end
    end
  end

  // Fault capture registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= CAUSE_NONE;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign o_fault_valid = fault_valid_q;
  assign o_fault_addr  = fault_addr_q;
  assign o_fault_cause = fault_cause_q;

`ifdef MEM_REGION_MAPPER_FAULT_CNT_EN
  logic [15:0] fault_cnt_q, fault_cnt_d;

  // Saturating faulting-cycle counter; a clear cycle that also faults counts 1
  always_comb begin
    fault_cnt_d = i_fault_clr ? 16'd0 : fault_cnt_q;
    if (any_fault && (fault_cnt_d != 16'hFFFF)) begin
      fault_cnt_d = fault_cnt_d + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fault_cnt_q <= '0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign o_fault_cnt = fault_cnt_q;
`endif

endmodule
